bit_serial_adder: RTL and testbench
===================================

# bit_serial_adder

- Multi-cycle WIDTH-bit adder that processes one bit per clock, LSB first.
- Built around a single one-bit full-adder cell plus a carry flip-flop.
- Sits directly downstream of the one-bit combinational adder cells: it consumes their sum/carry each cycle and turns them into a registered multi-bit result with a start/done handshake.
- Trades WIDTH cycles of latency for one adder cell instead of WIDTH cells.

## Interface

Parameters:
- WIDTH, default 8 — operand and result width in bits; legal range 1 to 64.

Ports:
- clk  input  1  — single clock; all state updates on the rising edge.
- rst  input  1  — synchronous, active-high reset.
- start  input  1  — request a new addition; sampled only in IDLE.
- a  input  WIDTH  — operand A; captured on the accepted start edge.
- b  input  WIDTH  — operand B; captured on the accepted start edge.
- sub  input  1  — subtract select; present only when SERIAL_ADDER_SUB_EN is defined; captured with the operands.
- busy  output  1  — high while bits are being processed (SHIFT state).
- done  output  1  — one-cycle pulse; sum and cout are valid from this cycle onward.
- sum  output  WIDTH  — result modulo 2^WIDTH; held until the next accepted start.
- cout  output  1  — carry out of bit WIDTH-1; held with sum.

## Operation

- State machine: IDLE, SHIFT, DONE.
- **IDLE**
  - start=1: load a/b into operand shift registers, clear carry, clear the sum shift register, clear the bit counter, go to SHIFT.
  - start=0: stay in IDLE.
- **SHIFT**, each cycle:
  - s = a_sr[0] ^ b_sr[0] ^ c.
  - c_next = majority(a_sr[0], b_sr[0], c).
  - Shift a_sr and b_sr right by one.
  - Shift s into the sum register at the MSB (right shift), so bit i lands at position i after WIDTH shifts.
  - Increment the counter.
  - After the WIDTH-th shift: go to DONE.
- **DONE**
  - Drive done=1 for exactly one cycle; cout = final carry.
  - Unconditionally return to IDLE.
- The sum register and cout are not modified in IDLE or DONE, so the result stays stable until the next accepted start.
- start is ignored in SHIFT and DONE; operands presented then are discarded.
- Counter width is clog2(WIDTH+1).
- WIDTH=1 is legal: exactly one SHIFT cycle.
- **Reset**: state=IDLE; busy=0, done=0, sum=0, cout=0; operand registers, carry and counter cleared.
- **Reset mid-operation**: the operation is aborted; all outputs read reset values in the cycle after the reset edge; no done pulse is produced for the aborted operation.
- rst and start high on the same edge: rst wins.

## Timing

- Accepted start at edge E0:
  - busy=1 after E0 through edge E0+WIDTH.
  - At edge E0+WIDTH: busy=0, done=1, sum and cout final.
  - At edge E0+WIDTH+1: done=0, state IDLE.
- Earliest next accepted start: edge E0+WIDTH+2. Throughput is one operation per WIDTH+2 cycles.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration

- **SERIAL_ADDER_SUB_EN defined:**
  - sub port exists.
  - When sub=1 is captured at start, B is inverted as it is loaded and the carry is initialised to 1, so sum = (a - b) mod 2^WIDTH.
  - cout=1 means no borrow (a >= b, unsigned).
  - sub=0 behaves exactly as addition.
- **SERIAL_ADDER_SUB_EN undefined:** no sub port; the block only adds, with carry initialised to 0.

## Test plan

All scenarios use WIDTH=8.
- a=0x35, b=0x1A, start pulse at E0 -> busy for 8 cycles; done at E0+8 with sum=0x4F, cout=0.
- a=0xFF, b=0x01 -> sum=0x00, cout=1; a=0xFF, b=0xFF -> sum=0xFE, cout=1.
- Start 0x10+0x20, then at E0+3 drive start=1 with a=0xAA, b=0x55 -> ignored; result sum=0x30; sum holds 0x30 for 10 idle cycles after done.
- Start 0x80+0x80, assert rst at E0+4 -> next cycle busy=0, done=0, sum=0, cout=0; no done pulse; subsequent 0x01+0x02 yields sum=0x03.
- SERIAL_ADDER_SUB_EN defined:
  - 0x10 - 0x01 -> sum=0x0F, cout=1.
  - 0x01 - 0x02 -> sum=0xFF, cout=0.
  - sub=0 with 0x35+0x1A -> sum=0x4F.
- Back-to-back: start held high continuously -> operations accepted at E0, E0+10, E0+20; each gives exactly one done pulse.

Source files
------------

// File: rtl/bit_serial_adder.sv
// Multi-cycle adder: one full-adder cell plus a carry flop, one bit per clock, LSB first.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN, which adds the sub port.
module bit_serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic [WIDTH-1:0] sum_nx;
    logic [WIDTH-1:0] b_ld;
    logic             carry;
    logic             c_ld;
    logic             s;
    logic             c_nx;
    logic [CW-1:0]    cnt;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SHIFT;
            SHIFT:   if (cnt == LAST) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Subtraction is a + ~b + 1: invert B on load and seed the carry with 1.
`ifdef SERIAL_ADDER_SUB_EN
    assign b_ld = sub ? ~b : b;
    assign c_ld = sub;
`else
    assign b_ld = b;
    assign c_ld = 1'b0;
`endif

    assign s    = a_sr[0] ^ b_sr[0] ^ carry;
    assign c_nx = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);

    if (WIDTH == 1) begin : g_w1
        assign sum_nx = s;
    end else begin : g_wn
        assign sum_nx = {s, sum_sr[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b_ld;
                        sum_sr <= '0;
                        carry  <= c_ld;
                        cnt    <= '0;
                    end
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    sum_sr <= sum_nx;
                    carry  <= c_nx;
                    cnt    <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Outputs decode flops only; carry doubles as cout since it is frozen outside SHIFT.
    assign busy = (state == SHIFT);
    assign done = (state == DONE);
    assign sum  = sum_sr;
    assign cout = carry;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder (WIDTH=8) against an arithmetic reference model.
module tb_bit_serial_adder;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         sub_r = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int n_checks = 0;
    int n_fail   = 0;

    bit_serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub_r),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, observed running expected finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                         output logic [W-1:0] es, output logic ec);
        int unsigned r;
        if (s) begin
            r  = (x + 256 - y) % 256;
            es = r[W-1:0];
            ec = (x >= y);
        end else begin
            r  = x + y;
            es = r[W-1:0];
            ec = (r >= 256);
        end
    endtask

    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        logic [W-1:0] es;
        logic         ec;
        model(x, y, s, es, ec);
        a = x; b = y; sub_r = s; start = 1'b1;
        tick();
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); sub_r = 1'($urandom);
        chk("busy_e0", busy, 1);
        chk("done_e0", done, 0);
        for (int k = 1; k < W; k++) begin
            tick();
            chk("busy_shift", busy, 1);
            chk("done_shift", done, 0);
        end
        tick();
        chk("busy_done", busy, 0);
        chk("done_pulse", done, 1);
        chk("sum", sum, es);
        chk("cout", cout, ec);
        tick();
        chk("done_low", done, 0);
        chk("busy_idle", busy, 0);
        chk("sum_hold", sum, es);
        chk("cout_hold", cout, ec);
    endtask

    initial begin
        logic [W-1:0] qa [$];
        logic [W-1:0] qb [$];
        logic [W-1:0] es;
        logic         ec;
        int           pulses;

        rst = 1'b1; start = 1'b1; a = 8'h12; b = 8'h34;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        rst = 1'b0; start = 1'b0;
        tick();
        chk("rst_idle_busy", busy, 0);

        do_op(8'h35, 8'h1A, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0);
        do_op(8'hFF, 8'hFF, 1'b0);
        do_op(8'h00, 8'h00, 1'b0);

        // start during SHIFT must be ignored
        a = 8'h10; b = 8'h20; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        a = 8'hAA; b = 8'h55; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 4; k < W; k++) tick();
        tick();
        chk("ign_done", done, 1);
        chk("ign_sum", sum, 8'h30);
        chk("ign_cout", cout, 0);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("ign_hold_sum", sum, 8'h30);
            chk("ign_hold_done", done, 0);
        end

        // reset mid-operation
        a = 8'h80; b = 8'h80; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_sum", sum, 0);
        chk("mid_rst_cout", cout, 0);
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done) pulses++;
        end
        chk("mid_rst_no_done", pulses, 0);
        do_op(8'h01, 8'h02, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        do_op(8'h10, 8'h01, 1'b1);
        do_op(8'h01, 8'h02, 1'b1);
        do_op(8'h35, 8'h1A, 1'b0);
        do_op(8'h80, 8'h80, 1'b1);
`endif

        // back-to-back with start held; operands change every cycle
        sub_r = 1'b0;
        pulses = 0;
        start = 1'b1;
        for (int k = 0; k < 30; k++) begin
            a = W'($urandom); b = W'($urandom);
            if (k % 10 == 0) begin
                qa.push_back(a);
                qb.push_back(b);
            end
            tick();
            chk("b2b_busy", busy, ((k % 10) <= 7) ? 1 : 0);
            chk("b2b_done", done, ((k % 10) == 8) ? 1 : 0);
            if (done) pulses++;
            if ((k % 10) == 8 && qa.size() > 0) begin
                model(qa.pop_front(), qb.pop_front(), 1'b0, es, ec);
                chk("b2b_sum", sum, es);
                chk("b2b_cout", cout, ec);
            end
        end
        start = 1'b0;
        tick();
        chk("b2b_pulses", pulses, 3);
        for (int k = 0; k < 12; k++) tick();

        for (int i = 0; i < 20; i++) begin
`ifdef SERIAL_ADDER_SUB_EN
            do_op(W'($urandom), W'($urandom), 1'($urandom));
`else
            do_op(W'($urandom), W'($urandom), 1'b0);
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
